// File: rtl/keypad_scanner.sv
// 4x4 CHIP-8 hex keypad scanner: walks one active-low column at a time,
// samples the synchronized rows and debounces each of the 16 keys.
module keypad_scanner #(
   parameter int unsigned SCAN_DIV       = 1000,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [3:0]  row_in,
   output logic [3:0]  col_out,
   output logic [15:0] keys_out,
   output logic        any_key,
   output logic        key_event,
   output logic [3:0]  key_code
);

   localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CntW-1:0] Thresh = CntW'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {StCol0, StCol1, StCol2, StCol3} state_e;

   state_e            state_q, state_d;
   logic [DivW-1:0]   div_q, div_d;
   logic [3:0]        sync1_q, sync1_d, sync2_q, sync2_d;
   logic [3:0]        col_q, col_d;
   logic [15:0]       keys_q, keys_d;
   logic [CntW-1:0]   cnt_q [16];
   logic [CntW-1:0]   cnt_d [16];
   logic              any_q, any_d;
   logic              event_q, event_d;
   logic [3:0]        code_q, code_d;
   logic              sample;
   logic [15:0]       rise;
   logic [3:0]        k_idx;
   logic              raw;

   function automatic logic [3:0] key_at(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] k;
      case ({r, c})
         4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hC;
         4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hD;
         4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hE;
         4'hC: k = 4'hA;  4'hD: k = 4'h0;  4'hE: k = 4'hB;  4'hF: k = 4'hF;
      endcase
      return k;
   endfunction

   always_comb begin
      sync1_d = row_in;
      sync2_d = sync1_q;
      sample  = (div_q == DivW'(SCAN_DIV - 1));
      div_d   = sample ? '0 : div_q + 1'b1;
      state_d = state_q;
      if (sample) begin
         case (state_q)
            StCol0: state_d = StCol1;
            StCol1: state_d = StCol2;
            StCol2: state_d = StCol3;
            StCol3: state_d = StCol0;
         endcase
      end
      col_d          = 4'hF;
      col_d[state_d] = 1'b0;

      keys_d = keys_q;
      cnt_d  = cnt_q;
      rise   = '0;
      k_idx  = '0;
      raw    = 1'b0;
      // Only the four keys of the driven column are touched at its sample edge.
      for (int r = 0; r < 4; r++) begin
         k_idx = key_at(2'(r), state_q);
         raw   = ~sync2_q[r];
         if (sample) begin
            if (raw == keys_q[k_idx]) begin
               cnt_d[k_idx] = '0;
            end else if (cnt_q[k_idx] == Thresh - 1'b1) begin
               cnt_d[k_idx]  = '0;
               keys_d[k_idx] = raw;
               rise[k_idx]   = raw;
            end else begin
               cnt_d[k_idx] = cnt_q[k_idx] + 1'b1;
            end
         end
      end

      event_d = |rise;
      code_d  = code_q;
      for (int k = 15; k >= 0; k--) begin
         if (rise[k]) code_d = 4'(k);
      end
      any_d = |keys_d;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= StCol0;
         div_q   <= '0;
         sync1_q <= 4'hF;
         sync2_q <= 4'hF;
         col_q   <= 4'b1110;
         keys_q  <= '0;
         cnt_q   <= '{default: '0};
         any_q   <= 1'b0;
         event_q <= 1'b0;
         code_q  <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         col_q   <= col_d;
         keys_q  <= keys_d;
         cnt_q   <= cnt_d;
         any_q   <= any_d;
         event_q <= event_d;
         code_q  <= code_d;
      end
   end

   assign col_out   = col_q;
   assign keys_out  = keys_q;
   assign any_key   = any_q;
   assign key_event = event_q;
   assign key_code  = code_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a behavioural key matrix drives the rows from col_out,
// expected key codes are queued at stimulus time and popped on every key_event.
module tb_keypad_scanner;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic [3:0]  row_in;
   logic [3:0]  col_out;
   logic [15:0] keys_out;
   logic        any_key;
   logic        key_event;
   logic [3:0]  key_code;

   logic [15:0] held = '0;
   logic        zero_rows = 1'b1;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   logic [3:0]  exp_q [$];
   int          kmap [4][4] = '{'{1, 2, 3, 12}, '{4, 5, 6, 13}, '{7, 8, 9, 14}, '{10, 0, 11, 15}};

   keypad_scanner #(
      .SCAN_DIV       (4),
      .DEBOUNCE_SCANS (2)
   ) dut (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .row_in    (row_in),
      .col_out   (col_out),
      .keys_out  (keys_out),
      .any_key   (any_key),
      .key_event (key_event),
      .key_code  (key_code)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) begin
      if (rst_in) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // Pressed key pulls its row low only while its column is driven.
   always_comb begin
      row_in = 4'hF;
      if (zero_rows) begin
         row_in = 4'h0;
      end else begin
         for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
               if (!col_out[c] && held[kmap[r][c]]) row_in[r] = 1'b0;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk_in);
   endtask

   always @(negedge clk_in) begin
      if (!rst_in && key_event) begin
         check("event_pending", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) check("event_code", key_code, exp_q.pop_front());
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset held three edges with all rows low.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_in);
         check("rst_col", col_out, 4'b1110);
         check("rst_keys", keys_out, 0);
         check("rst_event", key_event, 0);
      end
      rst_in    = 1'b0;
      zero_rows = 1'b0;
      held      = 16'h0020;
      exp_q.push_back(4'h5);

      for (int n = 0; n < 16; n++) begin
         wait_cyc(n);
         check($sformatf("walk_col_%0d", n), col_out, ~(4'b0001 << (n / 4)) & 4'hF);
      end

      // Key 5 registers after the second column-1 sample.
      wait_cyc(23);
      check("k5_before", keys_out, 0);
      wait_cyc(24);
      check("k5_keys", keys_out, 16'h0020);
      check("k5_event", key_event, 1);
      check("k5_code", key_code, 5);
      check("k5_any", any_key, 1);
      wait_cyc(25);
      check("k5_pulse_end", key_event, 0);
      wait_cyc(56);
      check("k5_held", keys_out, 16'h0020);

      held = 16'h0000;
      wait_cyc(87);
      check("rel_before", keys_out, 16'h0020);
      wait_cyc(88);
      check("rel_keys", keys_out, 0);
      check("rel_code", key_code, 5);
      check("rel_any", any_key, 0);

      // Key A seen on isolated column-0 samples only.
      wait_cyc(96);
      held = 16'h0400;
      wait_cyc(100);
      held = 16'h0000;
      wait_cyc(128);
      held = 16'h0400;
      wait_cyc(132);
      held = 16'h0000;
      wait_cyc(140);
      check("glitch_keys", keys_out, 0);

      wait_cyc(144);
      held = 16'h0208;
      exp_q.push_back(4'h3);
      wait_cyc(171);
      check("sim_before", keys_out, 0);
      wait_cyc(172);
      check("sim_keys", keys_out, 16'h0208);
      check("sim_event", key_event, 1);
      check("sim_code", key_code, 3);
      check("sim_any", any_key, 1);
      wait_cyc(173);
      check("sim_pulse_end", key_event, 0);
      wait_cyc(176);
      held = 16'h0000;
      wait_cyc(204);
      check("sim_rel", keys_out, 0);
      check("sim_rel_code", key_code, 3);

      // Key F gets one sample, then reset wipes its progress.
      wait_cyc(208);
      held = 16'h8000;
      wait_cyc(224);
      rst_in = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk_in);
         check("mid_rst_keys", keys_out, 0);
         check("mid_rst_col", col_out, 4'b1110);
         check("mid_rst_code", key_code, 0);
      end
      rst_in = 1'b0;
      exp_q.push_back(4'hF);
      wait_cyc(16);
      check("f_one_sample", keys_out, 0);
      wait_cyc(32);
      check("f_keys", keys_out, 16'h8000);
      check("f_event", key_event, 1);
      check("f_code", key_code, 4'hF);
      wait_cyc(40);
      check("queue_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
